// File: rtl/cell_ram_arbiter_ctrl.sv
// Two-port round-robin arbiter and one-cycle access sequencer for a
// word-organised RAM built from single-bit cells with tri-state read data.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req0/we0/addr0/wdata0, ack0    requester 0 request bundle and ack pulse
//   req1/we1/addr1/wdata1, ack1    requester 1 request bundle and ack pulse
//   rdata                          registered read data, valid with the ack
//   busy                           high whenever the sequencer is not idle
//   mem_cs/mem_w/mem_r/mem_din     registered row select, strobes, write data
//   mem_dout                       array read data (Z when not read-selected)
module cell_ram_arbiter_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0,
    input  logic                      we0,
    input  logic [ADDR_W-1:0]         addr0,
    input  logic [DATA_W-1:0]         wdata0,
    output logic                      ack0,
    input  logic                      req1,
    input  logic                      we1,
    input  logic [ADDR_W-1:0]         addr1,
    input  logic [DATA_W-1:0]         wdata1,
    output logic                      ack1,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [(2**ADDR_W)-1:0]    mem_cs,
    output logic                      mem_w,
    output logic                      mem_r,
    output logic [DATA_W-1:0]         mem_din,
    input  logic [DATA_W-1:0]         mem_dout
);

    localparam int WORDS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    logic   owner;
    logic   last_owner;

    // Grant selection, evaluated every cycle but only consumed in IDLE.
    logic              any_req;
    logic              grant1;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    always_comb begin
        any_req = req0 | req1;
        // On contention the requester that did not win last time goes next.
        grant1  = req1 & (~req0 | ~last_owner);
        g_we    = grant1 ? we1    : we0;
        g_addr  = grant1 ? addr1  : addr0;
        g_wdata = grant1 ? wdata1 : wdata0;
    end

    function automatic logic [WORDS-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [WORDS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // The request bundle is captured straight into the registered array
    // drivers, so later requester changes cannot reach the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b0;
            mem_cs     <= '0;
            mem_w      <= 1'b0;
            mem_r      <= 1'b0;
            mem_din    <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner  <= grant1;
                        busy   <= 1'b1;
                        mem_cs <= onehot(g_addr);
                        if (g_we) begin
                            mem_w   <= 1'b1;
                            mem_din <= g_wdata;
                            state   <= WRITE;
                        end else begin
                            mem_r   <= 1'b1;
                            state   <= READ;
                        end
                    end
                end
                WRITE: begin
                    mem_cs  <= '0;
                    mem_w   <= 1'b0;
                    mem_din <= '0;
                    ack0    <= ~owner;
                    ack1    <= owner;
                    state   <= RESP;
                end
                READ: begin
                    // Only place mem_dout is sampled; Z elsewhere never lands.
                    rdata  <= mem_dout;
                    mem_cs <= '0;
                    mem_r  <= 1'b0;
                    ack0   <= ~owner;
                    ack1   <= owner;
                    state  <= RESP;
                end
                RESP: begin
                    last_owner <= owner;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
